norm_result_fifo: RTL and testbench
===================================

NORM_RESULT_FIFO -- requirements
Module: norm_result_fifo

Interface
REQ-001 Parameter: WIDTH, 10, sample width; matches the norm-accumulator result g.
REQ-002 Parameter: DEPTH, 8, FIFO entries; a power of two, at least 2.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: in_data  input  WIDTH  result sample from the upstream norm stage (its g).
REQ-006 Port: in_valid  input  1  upstream sample valid (its valid_out); no backpressure to upstream.
REQ-007 Port: out_data  output  WIDTH  head-of-FIFO sample.
REQ-008 Port: out_valid  output  1  FIFO non-empty; out_data is meaningful.
REQ-009 Port: out_ready  input  1  consumer accepts the head sample.
REQ-010 Port: count  output  $clog2(DEPTH+1)  number of stored samples.
REQ-011 Port: full  output  1  count == DEPTH.
REQ-012 Port: overflow  output  1  sticky flag; at least one sample was dropped.
REQ-013 Port: peak  output  WIDTH  largest sample accepted since reset.

Function
REQ-014 Push = in_valid && (!full || pop); pop = out_valid && out_ready; both evaluated on the same edge.
REQ-015 On push, in_data is written at the write pointer, and the write pointer advances modulo DEPTH.
REQ-016 On pop, the read pointer advances modulo DEPTH.
REQ-017 Pointers wrap from DEPTH-1 to 0 with no gap or duplicate.
REQ-018 The block is show-ahead: out_data = mem[rd_ptr] combinationally, and out_valid = (count != 0).
REQ-019 Write-to-read latency: a sample pushed at edge k appears on out_data/out_valid after edge k when the FIFO was empty.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-021 When empty, a simultaneous in_valid and out_ready produce a push only, because pop requires out_valid.
REQ-022 When full, in_valid with pop pushes and pops on the same edge; count stays DEPTH and nothing is lost.
REQ-023 When full, in_valid without pop drops the sample; memory, pointers, count and peak stay unchanged, and overflow is set at that edge.
REQ-024 overflow stays 1 until reset; further drops do not change it.
REQ-025 peak updates on push only: peak <= max(peak, in_data), using unsigned comparison.
REQ-026 out_ready while empty has no effect.
REQ-027 Sample order out equals accepted order in (strict FIFO).
REQ-028 Outputs carry no X after the first reset edge; unwritten memory contents are don't care while out_valid = 0.

Reset
REQ-029 While reset = 1 at an edge: pointers = 0, count = 0, full = 0, out_valid = 0, overflow = 0, peak = 0.
REQ-030 Reset overrides a simultaneous push or pop, and stored samples are discarded.
REQ-031 Reset mid-operation, including when full or with overflow set, returns to the REQ-029 state on that edge.
REQ-032 Memory contents need not be cleared by reset.

Verification
REQ-033 Reset; push 21, 41 on consecutive edges with out_ready = 0 -> count = 2, out_valid = 1, out_data = 21, peak = 41.
REQ-034 From REQ-033, out_ready = 1 for 2 edges with no push -> out_data 21 then 41; count = 0, out_valid = 0; peak stays 41.
REQ-035 Push 1..8 with out_ready = 0, then push 99 -> full = 1, count = 8, overflow = 1, peak = 8; draining yields 1..8 and never 99.
REQ-036 Full FIFO holding 1..8: push 76 with out_ready = 1 -> count stays 8 and full stays 1; the drain sequence is 2..8, 76.
REQ-037 Wrap test: 20 pushes of 10..29, each popped one cycle later -> outputs 10..29 in order; count never exceeds 2; overflow = 0.
REQ-038 Reset asserted while count = 5 and overflow = 1, with in_valid = 1 on the same edge -> count = 0, out_valid = 0, overflow = 0, peak = 0 after that edge.

Source files
------------

// File: rtl/norm_result_fifo.sv
// Show-ahead result FIFO behind the norm accumulator: buffers g samples and drops them when full.
// It also tracks a sticky overflow flag and the peak accepted sample.
module norm_result_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic [WIDTH-1:0]           peak
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign out_data  = mem[rd_ptr];

    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && !push;

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // DEPTH is a power of two, so natural pointer roll-over is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            peak     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (in_data > peak) begin
                    peak <= in_data;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_norm_result_fifo.sv
// Scoreboard bench for norm_result_fifo: accepted samples are queued as they are driven
// and compared against what the FIFO delivers when the consumer takes them.
module tb_norm_result_fifo;

    localparam int WIDTH = 10;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overflow;
    logic [WIDTH-1:0] peak;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               mdl_cnt = 0;
    logic [WIDTH-1:0] mdl_peak = '0;
    logic             mdl_ovf = 1'b0;

    norm_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .full(full),
        .overflow(overflow),
        .peak(peak)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // One clock: drive inputs, capture the head if the model predicts a pop, advance the model.
    task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
        logic p_pop;
        logic p_push;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        p_pop  = (mdl_cnt != 0) && r;
        p_push = v && ((mdl_cnt < DEPTH) || p_pop);
        if (p_pop) got_q.push_back(out_data);
        if (p_push) begin
            exp_q.push_back(d);
            if (d > mdl_peak) mdl_peak = d;
        end
        if (v && !p_push) mdl_ovf = 1'b1;
        mdl_cnt = mdl_cnt + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input logic v, input logic [WIDTH-1:0] d, input logic r);
        reset     = 1'b1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        got_q.delete();
        mdl_cnt  = 0;
        mdl_peak = '0;
        mdl_ovf  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, '0, 1'b0);
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (peak !== '0) begin failures++; $display("FAIL reset_peak got %0d want 0", peak); end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] e;
        do_reset(1'b0, '0, 1'b0);
        drive_cycle(1'b1, 10'd21, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 10'd21) begin failures++; $display("FAIL basic_latency got v=%0b d=%0d want v=1 d=21", out_valid, out_data); end
        drive_cycle(1'b1, 10'd41, 1'b0);
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL basic_count got %0d want 2", count); end
        checks++; if (out_valid !== 1'b1 || out_data !== 10'd21) begin failures++; $display("FAIL basic_head got v=%0b d=%0d want v=1 d=21", out_valid, out_data); end
        checks++; if (peak !== 10'd41) begin failures++; $display("FAIL basic_peak got %0d want 41", peak); end
        drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        checks++; if (count !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_drained got cnt=%0d v=%0b want cnt=0 v=0", count, out_valid); end
        checks++; if (peak !== 10'd41) begin failures++; $display("FAIL basic_peak_hold got %0d want 41", peak); end
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL basic_pops got %0d want 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL basic_order got %0d want %0d", g, e); end
        end
    endtask

    task automatic test_empty_ready();
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] e;
        do_reset(1'b0, '0, 1'b0);
        drive_cycle(1'b0, '0, 1'b1);
        checks++; if (count !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL empty_ready got cnt=%0d v=%0b want cnt=0 v=0", count, out_valid); end
        drive_cycle(1'b1, 10'd5, 1'b1);
        checks++; if (count !== 4'd1 || out_data !== 10'd5) begin failures++; $display("FAIL empty_push_only got cnt=%0d d=%0d want cnt=1 d=5", count, out_data); end
        drive_cycle(1'b0, '0, 1'b1);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL empty_order got %0d want %0d", g, e); end
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] e;
        do_reset(1'b0, '0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) drive_cycle(1'b1, WIDTH'(i), 1'b0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_drop got %0b want 0", overflow); end
        drive_cycle(1'b1, 10'd99, 1'b0);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL ovf_full got full=%0b cnt=%0d want full=1 cnt=8", full, count); end
        checks++; if (overflow !== mdl_ovf || overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        checks++; if (peak !== 10'd8) begin failures++; $display("FAIL ovf_peak got %0d want 8", peak); end
        drive_cycle(1'b1, 10'd123, 1'b0);
        checks++; if (overflow !== 1'b1 || peak !== mdl_peak) begin failures++; $display("FAIL ovf_sticky got ovf=%0b peak=%0d want ovf=1 peak=%0d", overflow, peak, mdl_peak); end
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, '0, 1'b1);
        checks++; if (count !== '0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_drained got cnt=%0d ovf=%0b want cnt=0 ovf=1", count, overflow); end
        checks++; if (got_q.size() != DEPTH) begin failures++; $display("FAIL ovf_pops got %0d want %0d", got_q.size(), DEPTH); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e || g == 10'd99) begin failures++; $display("FAIL ovf_order got %0d want %0d", g, e); end
        end
    endtask

    task automatic test_full_pushpop();
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] e;
        do_reset(1'b0, '0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) drive_cycle(1'b1, WIDTH'(i), 1'b0);
        drive_cycle(1'b1, 10'd76, 1'b1);
        checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL fullpp_count got cnt=%0d full=%0b want cnt=8 full=1", count, full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got %0b want 0", overflow); end
        checks++; if (peak !== 10'd76) begin failures++; $display("FAIL fullpp_peak got %0d want 76", peak); end
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, '0, 1'b1);
        checks++; if (got_q.size() != DEPTH + 1) begin failures++; $display("FAIL fullpp_pops got %0d want %0d", got_q.size(), DEPTH + 1); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL fullpp_order got %0d want %0d", g, e); end
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] e;
        int max_cnt;
        do_reset(1'b0, '0, 1'b0);
        max_cnt = 0;
        for (int i = 0; i <= 20; i++) begin
            drive_cycle(i < 20, WIDTH'(10 + i), i > 0);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        checks++; if (max_cnt > 2) begin failures++; $display("FAIL wrap_max_count got %0d want <=2", max_cnt); end
        checks++; if (overflow !== 1'b0 || count !== '0) begin failures++; $display("FAIL wrap_end got ovf=%0b cnt=%0d want ovf=0 cnt=0", overflow, count); end
        checks++; if (got_q.size() != 20) begin failures++; $display("FAIL wrap_pops got %0d want 20", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL wrap_order got %0d want %0d", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] e;
        do_reset(1'b0, '0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) drive_cycle(1'b1, WIDTH'(i), 1'b0);
        drive_cycle(1'b1, 10'd99, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1);
        checks++; if (count !== 4'd5 || overflow !== 1'b1) begin failures++; $display("FAIL mid_pre got cnt=%0d ovf=%0b want cnt=5 ovf=1", count, overflow); end
        do_reset(1'b1, 10'd500, 1'b1);
        checks++; if (count !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset got cnt=%0d v=%0b want cnt=0 v=0", count, out_valid); end
        checks++; if (overflow !== 1'b0 || peak !== '0) begin failures++; $display("FAIL mid_reset_flags got ovf=%0b peak=%0d want ovf=0 peak=0", overflow, peak); end
        drive_cycle(1'b1, 10'd7, 1'b0);
        drive_cycle(1'b0, '0, 1'b1);
        checks++; if (count !== '0) begin failures++; $display("FAIL mid_after got cnt=%0d want 0", count); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL mid_order got %0d want %0d", g, e); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_empty_ready();
        test_overflow();
        test_full_pushpop();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
